video_timing_gen: RTL and testbench
===================================

# video_timing_gen

Parametrised raster timing generator for the display path of the SoC. It replaces fixed 640x480 constants with default timings set by parameters plus eight runtime-writable shadow registers, applied atomically at frame boundaries. It produces sync, data-enable and pixel coordinates, delayed by a configurable pipeline depth so they line up with the pixel/character pipeline feeding the VGA DAC pins. It sits between the SoC register bus (display region) and the pixel datapath.

## Interface

Parameters:
- CW, 12: counter/config width; totals must fit in CW bits.
- H_ACTIVE, 640: default horizontal active pixels.
- H_FP, 16: default horizontal front porch.
- H_SYNC, 96: default horizontal sync width.
- H_BP, 48: default horizontal back porch.
- V_ACTIVE, 480: default active lines.
- V_FP, 10: default vertical front porch.
- V_SYNC, 2: default vertical sync width.
- V_BP, 33: default vertical back porch.
- H_POL, 0: hsync active level (0 = negative).
- V_POL, 0: vsync active level.
- DELAY, 0: extra output register stages, 0..7.

Ports:
- clk  in  1  pixel clock; the single clock.
- reset_i  in  1  synchronous, active-high reset.
- cfg_we_i  in  1  shadow register write strobe.
- cfg_addr_i  in  3  0 H_ACTIVE, 1 H_FP, 2 H_SYNC, 3 H_BP, 4 V_ACTIVE, 5 V_FP, 6 V_SYNC, 7 V_BP.
- cfg_wdata_i  in  CW  write data.
- cfg_pending_o  out  1  shadow written but not yet applied.
- hsync_o  out  1  horizontal sync, polarity H_POL.
- vsync_o  out  1  vertical sync, polarity V_POL.
- de_o  out  1  active video.
- x_o  out  CW  horizontal position (0..H_TOTAL-1).
- y_o  out  CW  vertical position (0..V_TOTAL-1).
- line_start_o  out  1  one-cycle pulse at x=0.
- frame_start_o  out  1  one-cycle pulse at x=0,y=0.

## Operation

- Three register sets: shadow (bus-written), active (used by counters), counters hc/vc.
- H_TOTAL = ACT+FP+SYNC+BP, computed from active set in CW+2 bits; CW overflow is a configuration error, not checked.
- hc increments each clk; at H_TOTAL-1 wraps to 0 and vc increments; vc wraps at V_TOTAL-1.
- Decode: de = hc<H_ACT && vc<V_ACT; hsync active when H_ACT+H_FP <= hc < H_ACT+H_FP+H_SYNC; vsync likewise on vc (full lines, changes at hc=0).
- Shadow write: cfg_we_i stores cfg_wdata_i; value 0 is stored as 1. Sets pending.
- Apply: on the cycle hc=H_TOTAL-1 and vc=V_TOTAL-1, if pending, copy shadow to active and clear pending. A write in that same cycle is stored in shadow, takes effect next frame; pending stays set.
- Reset: shadow and active load parameter defaults; pending cleared.

## Timing

- Decode registered once, then DELAY further stages; all outputs (including x_o/y_o, pulses) pass the same stages and stay aligned. Latency from counter to outputs = 1+DELAY cycles.
- Reset values: hc=vc=0, de_o=0, hsync_o=~H_POL, vsync_o=~V_POL, x_o=y_o=0, pulses 0, cfg_pending_o=0; all delay stages flush to these values.
- First cycle after reset_i falls: counters at (0,0); outputs show (0,0) with de_o=1, frame_start_o=1, line_start_o=1 at cycle 1+DELAY after deassertion.
- Reset mid-frame: counters return to (0,0) next clk, no partial-line completion; pending shadow values discarded.
- cfg_pending_o updates the cycle after the write/apply (registered).

## Structure

- Package video_pkg: CW default, register address enum, timing_t struct {act, fp, sync, bp}, 640x480 default constants.
- Sub-module: video_axis_counter (one instance for H, one for V) — holds the count, wraps at total, decodes active/sync from a timing_t; video_timing_gen adds shadow/apply logic and the delay line.

## Test plan

- Defaults, DELAY=0: hsync_o low exactly for hc 656..751; line period 800; vsync_o low lines 490..491; frame period 420000 clk.
- Small mode (H 8/2/3/1, V 4/1/2/1 written via cfg): pending=1 until frame end, then period 14x8=112 clk; de_o high 32 cycles per frame.
- Write H_ACTIVE on exactly the apply cycle -> not applied that frame, pending stays 1, applied at next frame end.
- Write 0 to H_SYNC -> sync width 1.
- DELAY=3: frame_start_o first asserted 4 cycles after reset release; x_o/y_o/de_o aligned with it.
- Assert reset_i at (hc=300, vc=200) with pending write -> outputs go to reset values next clk, pending=0, defaults resumed.

Source files
------------

// File: rtl/video_pkg.sv
// Shared types and 640x480 default timings for the raster timing generator.
package video_pkg;

  localparam int VID_CW = 12;
  localparam int TIM_W  = 16;

  typedef enum logic [2:0] {
    ADDR_H_ACT  = 3'd0,
    ADDR_H_FP   = 3'd1,
    ADDR_H_SYNC = 3'd2,
    ADDR_H_BP   = 3'd3,
    ADDR_V_ACT  = 3'd4,
    ADDR_V_FP   = 3'd5,
    ADDR_V_SYNC = 3'd6,
    ADDR_V_BP   = 3'd7
  } cfg_addr_e;

  typedef struct packed {
    logic [TIM_W-1:0] act;
    logic [TIM_W-1:0] fp;
    logic [TIM_W-1:0] sync;
    logic [TIM_W-1:0] bp;
  } timing_t;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  function automatic timing_t make_timing(input int act, input int fp,
                                          input int sync, input int bp);
    timing_t t;
    t.act  = TIM_W'(act);
    t.fp   = TIM_W'(fp);
    t.sync = TIM_W'(sync);
    t.bp   = TIM_W'(bp);
    return t;
  endfunction

endpackage

// File: rtl/video_axis_counter.sv
// One raster axis: position counter that wraps at the timing total, with active/sync decode.
module video_axis_counter
  import video_pkg::*;
#(
  parameter int CW = VID_CW
) (
  input  logic          clk,
  input  logic          reset_i,
  input  logic          en_i,
  input  timing_t       tim_i,
  output logic [CW-1:0] cnt_o,
  output logic          last_o,
  output logic          active_o,
  output logic          sync_o
);

  localparam int SW = TIM_W + 2;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] cnt_w, act_w, sync_start, sync_end, total;

  assign act_w      = SW'(tim_i.act);
  assign sync_start = act_w + SW'(tim_i.fp);
  assign sync_end   = sync_start + SW'(tim_i.sync);
  assign total      = sync_end + SW'(tim_i.bp);
  assign cnt_w      = SW'(cnt_q);

  // >= keeps the counter from running away if it is ever beyond the total
  assign last_o = (cnt_w >= total - SW'(1));
  assign cnt_d  = last_o ? '0 : cnt_q + CW'(1);

  always_ff @(posedge clk) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o    = cnt_q;
  assign active_o = (cnt_w < act_w);
  assign sync_o   = (cnt_w >= sync_start) && (cnt_w < sync_end);

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: shadow/active timing registers applied at frame end,
// H/V counters, registered decode and a DELAY-deep aligned output line.
module video_timing_gen
  import video_pkg::*;
#(
  parameter int CW       = VID_CW,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int DELAY    = 0
) (
  input  logic          clk,
  input  logic          reset_i,
  input  logic          cfg_we_i,
  input  logic [2:0]    cfg_addr_i,
  input  logic [CW-1:0] cfg_wdata_i,
  output logic          cfg_pending_o,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic          de_o,
  output logic [CW-1:0] x_o,
  output logic [CW-1:0] y_o,
  output logic          line_start_o,
  output logic          frame_start_o
);

  typedef struct packed {
    logic          hsync;
    logic          vsync;
    logic          de;
    logic          ls;
    logic          fs;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
  } vout_t;

  localparam timing_t H_DEF   = make_timing(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam timing_t V_DEF   = make_timing(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam vout_t   OUT_RST = '{hsync: ~H_POL, vsync: ~V_POL, de: 1'b0, ls: 1'b0,
                                  fs: 1'b0, x: '0, y: '0};

  timing_t          h_shd_q, v_shd_q, h_act_q, v_act_q;
  logic             pending_q;
  logic [TIM_W-1:0] wval;
  logic [CW-1:0]    hc, vc;
  logic             h_last, v_last, h_active, v_active, h_sync, v_sync;
  logic             frame_end;
  vout_t            dec;
  vout_t            pipe_q [0:DELAY];

  video_axis_counter #(.CW(CW)) u_hcnt (
    .clk(clk), .reset_i(reset_i), .en_i(1'b1), .tim_i(h_act_q),
    .cnt_o(hc), .last_o(h_last), .active_o(h_active), .sync_o(h_sync)
  );

  video_axis_counter #(.CW(CW)) u_vcnt (
    .clk(clk), .reset_i(reset_i), .en_i(h_last), .tim_i(v_act_q),
    .cnt_o(vc), .last_o(v_last), .active_o(v_active), .sync_o(v_sync)
  );

  assign frame_end = h_last && v_last;
  // A zero-length interval would stall the raster, so it is stored as 1
  assign wval = (cfg_wdata_i == '0) ? TIM_W'(1) : TIM_W'(cfg_wdata_i);

  // A write landing on the apply cycle goes to shadow after the copy, so it waits a frame
  always_ff @(posedge clk) begin
    if (reset_i) begin
      h_shd_q   <= H_DEF;
      v_shd_q   <= V_DEF;
      h_act_q   <= H_DEF;
      v_act_q   <= V_DEF;
      pending_q <= 1'b0;
    end else begin
      if (frame_end && pending_q) begin
        h_act_q   <= h_shd_q;
        v_act_q   <= v_shd_q;
        pending_q <= 1'b0;
      end
      if (cfg_we_i) begin
        pending_q <= 1'b1;
        case (cfg_addr_i)
          ADDR_H_ACT:  h_shd_q.act  <= wval;
          ADDR_H_FP:   h_shd_q.fp   <= wval;
          ADDR_H_SYNC: h_shd_q.sync <= wval;
          ADDR_H_BP:   h_shd_q.bp   <= wval;
          ADDR_V_ACT:  v_shd_q.act  <= wval;
          ADDR_V_FP:   v_shd_q.fp   <= wval;
          ADDR_V_SYNC: v_shd_q.sync <= wval;
          ADDR_V_BP:   v_shd_q.bp   <= wval;
        endcase
      end
    end
  end

  always_comb begin
    dec       = OUT_RST;
    dec.hsync = h_sync ? H_POL : ~H_POL;
    dec.vsync = v_sync ? V_POL : ~V_POL;
    dec.de    = h_active && v_active;
    dec.ls    = (hc == '0);
    dec.fs    = (hc == '0) && (vc == '0);
    dec.x     = hc;
    dec.y     = vc;
  end

  // Stage 0 registers the decode; stages 1..DELAY only shift it
  always_ff @(posedge clk) begin
    if (reset_i) begin
      for (int i = 0; i <= DELAY; i++) pipe_q[i] <= OUT_RST;
    end else begin
      pipe_q[0] <= dec;
      for (int i = 1; i <= DELAY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign cfg_pending_o = pending_q;
  assign hsync_o       = pipe_q[DELAY].hsync;
  assign vsync_o       = pipe_q[DELAY].vsync;
  assign de_o          = pipe_q[DELAY].de;
  assign x_o           = pipe_q[DELAY].x;
  assign y_o           = pipe_q[DELAY].y;
  assign line_start_o  = pipe_q[DELAY].ls;
  assign frame_start_o = pipe_q[DELAY].fs;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: instance A uses 640x480 defaults with no delay, instance B a small
// 32x18 raster with DELAY=3 and positive vsync, used for the runtime configuration cases.
module tb_video_timing_gen;

  logic        clk;
  logic        reset_i;
  logic        we_a, we_b;
  logic [2:0]  addr;
  logic [11:0] wdata;

  logic        pend_a, hsync_a, vsync_a, de_a, ls_a, fs_a;
  logic [11:0] x_a, y_a;
  logic        pend_b, hsync_b, vsync_b, de_b, ls_b, fs_b;
  logic [11:0] x_b, y_b;

  int n_checks = 0;
  int n_fail   = 0;

  video_timing_gen #(.DELAY(0)) dut_a (
    .clk(clk), .reset_i(reset_i), .cfg_we_i(we_a), .cfg_addr_i(addr),
    .cfg_wdata_i(wdata), .cfg_pending_o(pend_a), .hsync_o(hsync_a),
    .vsync_o(vsync_a), .de_o(de_a), .x_o(x_a), .y_o(y_a),
    .line_start_o(ls_a), .frame_start_o(fs_a)
  );

  video_timing_gen #(
    .H_ACTIVE(20), .H_FP(4), .H_SYNC(6), .H_BP(2),
    .V_ACTIVE(10), .V_FP(2), .V_SYNC(3), .V_BP(3),
    .H_POL(1'b0), .V_POL(1'b1), .DELAY(3)
  ) dut_b (
    .clk(clk), .reset_i(reset_i), .cfg_we_i(we_b), .cfg_addr_i(addr),
    .cfg_wdata_i(wdata), .cfg_pending_o(pend_b), .hsync_o(hsync_b),
    .vsync_o(vsync_b), .de_o(de_b), .x_o(x_b), .y_o(y_b),
    .line_start_o(ls_b), .frame_start_o(fs_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic write_b(input logic [2:0] a, input logic [11:0] d);
    addr  = a;
    wdata = d;
    we_b  = 1'b1;
    @(negedge clk);
    we_b  = 1'b0;
  endtask

  task automatic wait_fs_b(output bit found);
    found = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (fs_b === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  // Starting on a frame_start cycle, gather one frame of B until the next frame_start
  task automatic frame_stats_b(output int period, output int de_n, output int hs_n,
                               output int vs_n, output bit ok);
    period = 0; de_n = 0; hs_n = 0; vs_n = 0; ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (de_b === 1'b1) de_n++;
      if (hsync_b === 1'b0) hs_n++;
      if (vsync_b === 1'b1) vs_n++;
      period++;
      @(negedge clk);
      if (fs_b === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    n_checks++; if (hsync_a !== 1'b1) begin n_fail++; $display("FAIL rst_hsync_a: got %b want 1", hsync_a); end
    n_checks++; if (vsync_a !== 1'b1) begin n_fail++; $display("FAIL rst_vsync_a: got %b want 1", vsync_a); end
    n_checks++; if (de_a !== 1'b0) begin n_fail++; $display("FAIL rst_de_a: got %b want 0", de_a); end
    n_checks++; if (x_a !== 12'd0) begin n_fail++; $display("FAIL rst_x_a: got %0d want 0", x_a); end
    n_checks++; if (y_a !== 12'd0) begin n_fail++; $display("FAIL rst_y_a: got %0d want 0", y_a); end
    n_checks++; if (ls_a !== 1'b0) begin n_fail++; $display("FAIL rst_ls_a: got %b want 0", ls_a); end
    n_checks++; if (fs_a !== 1'b0) begin n_fail++; $display("FAIL rst_fs_a: got %b want 0", fs_a); end
    n_checks++; if (pend_a !== 1'b0) begin n_fail++; $display("FAIL rst_pend_a: got %b want 0", pend_a); end
    n_checks++; if (hsync_b !== 1'b1) begin n_fail++; $display("FAIL rst_hsync_b: got %b want 1", hsync_b); end
    n_checks++; if (vsync_b !== 1'b0) begin n_fail++; $display("FAIL rst_vsync_b: got %b want 0", vsync_b); end
    n_checks++; if (de_b !== 1'b0) begin n_fail++; $display("FAIL rst_de_b: got %b want 0", de_b); end
    n_checks++; if (fs_b !== 1'b0) begin n_fail++; $display("FAIL rst_fs_b: got %b want 0", fs_b); end
    n_checks++; if (pend_b !== 1'b0) begin n_fail++; $display("FAIL rst_pend_b: got %b want 0", pend_b); end
  endtask

  task automatic test_first_pixel;
    int early_fs_b = 0;
    reset_i = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) begin
        n_checks++; if (fs_a !== 1'b1) begin n_fail++; $display("FAIL first_fs_a: got %b want 1", fs_a); end
        n_checks++; if (ls_a !== 1'b1) begin n_fail++; $display("FAIL first_ls_a: got %b want 1", ls_a); end
        n_checks++; if (de_a !== 1'b1) begin n_fail++; $display("FAIL first_de_a: got %b want 1", de_a); end
        n_checks++; if (x_a !== 12'd0 || y_a !== 12'd0) begin n_fail++; $display("FAIL first_xy_a: got %0d,%0d want 0,0", x_a, y_a); end
      end
      if (k < 4 && fs_b !== 1'b0) early_fs_b++;
      if (k == 4) begin
        n_checks++; if (fs_b !== 1'b1) begin n_fail++; $display("FAIL dly3_fs_b: got %b want 1", fs_b); end
        n_checks++; if (de_b !== 1'b1) begin n_fail++; $display("FAIL dly3_de_b: got %b want 1", de_b); end
        n_checks++; if (x_b !== 12'd0 || y_b !== 12'd0) begin n_fail++; $display("FAIL dly3_xy_b: got %0d,%0d want 0,0", x_b, y_b); end
      end
    end
    n_checks++; if (early_fs_b != 0) begin n_fail++; $display("FAIL dly3_early_fs_b: got %0d early pulses want 0", early_fs_b); end
  endtask

  task automatic test_default_line;
    int coord_err = 0, hs_err = 0, de_err = 0, vs_err = 0;
    int hs_low = 0, de_n = 0, ls_n = 0, ls_k = -1;
    int ex, ey;
    logic [11:0] exx, eyy;
    logic exp_hs, exp_de;
    for (int k = 5; k <= 804; k++) begin
      @(negedge clk);
      ex = (k - 1) % 800;
      ey = (k - 1) / 800;
      exx = 12'(ex);
      eyy = 12'(ey);
      exp_hs = (ex >= 656 && ex < 752) ? 1'b0 : 1'b1;
      exp_de = (ex < 640) ? 1'b1 : 1'b0;
      if (x_a !== exx || y_a !== eyy) coord_err++;
      if (hsync_a !== exp_hs) hs_err++;
      if (de_a !== exp_de) de_err++;
      if (vsync_a !== 1'b1) vs_err++;
      if (hsync_a === 1'b0) hs_low++;
      if (de_a === 1'b1) de_n++;
      if (ls_a === 1'b1) begin ls_n++; ls_k = k; end
    end
    n_checks++; if (coord_err != 0) begin n_fail++; $display("FAIL line_coords: got %0d errors want 0", coord_err); end
    n_checks++; if (hs_err != 0) begin n_fail++; $display("FAIL line_hsync_window: got %0d errors want 0", hs_err); end
    n_checks++; if (de_err != 0) begin n_fail++; $display("FAIL line_de_window: got %0d errors want 0", de_err); end
    n_checks++; if (vs_err != 0) begin n_fail++; $display("FAIL line_vsync_idle: got %0d errors want 0", vs_err); end
    n_checks++; if (hs_low != 96) begin n_fail++; $display("FAIL line_hsync_width: got %0d want 96", hs_low); end
    n_checks++; if (de_n != 640) begin n_fail++; $display("FAIL line_de_count: got %0d want 640", de_n); end
    n_checks++; if (ls_n != 1 || ls_k != 801) begin n_fail++; $display("FAIL line_period: got %0d pulses at k=%0d want 1 at 801", ls_n, ls_k); end
  endtask

  task automatic test_small_mode;
    bit found, ok;
    int p, d, h, v;
    wait_fs_b(found);
    n_checks++; if (!found) begin n_fail++; $display("FAIL small_sync_fs: got none want frame_start"); end
    write_b(3'd0, 12'd8);
    n_checks++; if (pend_b !== 1'b1) begin n_fail++; $display("FAIL small_pend_set: got %b want 1", pend_b); end
    write_b(3'd1, 12'd2);
    write_b(3'd2, 12'd3);
    write_b(3'd3, 12'd1);
    write_b(3'd4, 12'd4);
    write_b(3'd5, 12'd1);
    write_b(3'd6, 12'd2);
    write_b(3'd7, 12'd1);
    n_checks++; if (pend_b !== 1'b1 || pend_a !== 1'b0) begin n_fail++; $display("FAIL small_pend_hold: got b=%b a=%b want b=1 a=0", pend_b, pend_a); end
    wait_fs_b(found);
    n_checks++; if (!found) begin n_fail++; $display("FAIL small_apply_fs: got none want frame_start"); end
    n_checks++; if (pend_b !== 1'b0) begin n_fail++; $display("FAIL small_pend_clr: got %b want 0", pend_b); end
    n_checks++; if (x_b !== 12'd0 || y_b !== 12'd0 || de_b !== 1'b1) begin n_fail++; $display("FAIL small_fs_align: got x=%0d y=%0d de=%b want 0,0,1", x_b, y_b, de_b); end
    frame_stats_b(p, d, h, v, ok);
    n_checks++; if (!ok || p != 112) begin n_fail++; $display("FAIL small_period: got %0d (ok=%b) want 112", p, ok); end
    n_checks++; if (d != 32) begin n_fail++; $display("FAIL small_de_count: got %0d want 32", d); end
    n_checks++; if (h != 24) begin n_fail++; $display("FAIL small_hsync_count: got %0d want 24", h); end
    n_checks++; if (v != 28) begin n_fail++; $display("FAIL small_vsync_count: got %0d want 28", v); end
  endtask

  task automatic test_apply_cycle_write;
    bit found, ok;
    int p, d, h, v;
    write_b(3'd5, 12'd1);
    n_checks++; if (pend_b !== 1'b1) begin n_fail++; $display("FAIL edge_pre_pend: got %b want 1", pend_b); end
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      // Output lags the counters by 4, so output (9,7) means counters sit at (13,7)
      if (x_b === 12'd9 && y_b === 12'd7) begin found = 1'b1; break; end
      @(negedge clk);
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL edge_locate: got none want position 9,7"); end
    write_b(3'd0, 12'd6);
    n_checks++; if (pend_b !== 1'b1) begin n_fail++; $display("FAIL edge_pend_kept: got %b want 1", pend_b); end
    wait_fs_b(found);
    n_checks++; if (!found || pend_b !== 1'b1) begin n_fail++; $display("FAIL edge_not_applied: got found=%b pend=%b want 1,1", found, pend_b); end
    frame_stats_b(p, d, h, v, ok);
    n_checks++; if (!ok || p != 112) begin n_fail++; $display("FAIL edge_old_period: got %0d want 112", p); end
    n_checks++; if (pend_b !== 1'b0) begin n_fail++; $display("FAIL edge_pend_clr: got %b want 0", pend_b); end
    frame_stats_b(p, d, h, v, ok);
    n_checks++; if (!ok || p != 96) begin n_fail++; $display("FAIL edge_new_period: got %0d want 96", p); end
    n_checks++; if (d != 24) begin n_fail++; $display("FAIL edge_new_de: got %0d want 24", d); end
  endtask

  task automatic test_zero_sync;
    bit found, ok;
    int p, d, h, v;
    write_b(3'd2, 12'd0);
    wait_fs_b(found);
    n_checks++; if (!found) begin n_fail++; $display("FAIL zero_fs: got none want frame_start"); end
    frame_stats_b(p, d, h, v, ok);
    n_checks++; if (!ok || p != 80) begin n_fail++; $display("FAIL zero_period: got %0d want 80", p); end
    n_checks++; if (h != 8) begin n_fail++; $display("FAIL zero_hsync_width: got %0d want 8", h); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int p, d, h, v, first_k;
    write_b(3'd4, 12'd3);
    n_checks++; if (pend_b !== 1'b1) begin n_fail++; $display("FAIL mid_pend_set: got %b want 1", pend_b); end
    repeat (30) @(negedge clk);
    reset_i = 1'b1;
    @(negedge clk);
    n_checks++; if (x_b !== 12'd0 || y_b !== 12'd0) begin n_fail++; $display("FAIL mid_rst_xy: got %0d,%0d want 0,0", x_b, y_b); end
    n_checks++; if (de_b !== 1'b0 || fs_b !== 1'b0 || ls_b !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ctl: got de=%b fs=%b ls=%b want 0", de_b, fs_b, ls_b); end
    n_checks++; if (hsync_b !== 1'b1 || vsync_b !== 1'b0) begin n_fail++; $display("FAIL mid_rst_sync: got h=%b v=%b want 1,0", hsync_b, vsync_b); end
    n_checks++; if (pend_b !== 1'b0) begin n_fail++; $display("FAIL mid_rst_pend: got %b want 0", pend_b); end
    n_checks++; if (de_a !== 1'b0 || x_a !== 12'd0) begin n_fail++; $display("FAIL mid_rst_a: got de=%b x=%0d want 0,0", de_a, x_a); end
    reset_i = 1'b0;
    first_k = -1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (fs_b === 1'b1) begin first_k = k; break; end
    end
    n_checks++; if (first_k != 4) begin n_fail++; $display("FAIL mid_first_fs: got cycle %0d want 4", first_k); end
    frame_stats_b(p, d, h, v, ok);
    n_checks++; if (!ok || p != 576) begin n_fail++; $display("FAIL mid_default_period: got %0d want 576", p); end
    n_checks++; if (d != 200) begin n_fail++; $display("FAIL mid_default_de: got %0d want 200", d); end
    n_checks++; if (h != 108 || v != 96) begin n_fail++; $display("FAIL mid_default_sync: got h=%0d v=%0d want 108,96", h, v); end
  endtask

  initial begin
    reset_i = 1'b1;
    we_a    = 1'b0;
    we_b    = 1'b0;
    addr    = 3'd0;
    wdata   = 12'd0;
    repeat (5) @(negedge clk);
    test_reset;
    test_first_pixel;
    test_default_line;
    test_small_mode;
    test_apply_cycle_write;
    test_zero_sync;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
